dynamics_processor: RTL and testbench

Audio dynamics stage downstream of the RS232 wrapper: it consumes the runtime parameters `threshold_gate`, `threshold_comp`, `ratio` and `makeup` that the wrapper receives from the host, and applies a noise gate, hard-knee compressor and makeup gain to a stream of 16-bit signed samples. It sits between the ADC sample path and the DAC/effector chain. Each sample is processed with a fixed latency by a small FSM containing an iterative 16-cycle divider.

---
 rtl/dynamics_processor.sv | 189 ++++++++++++++++++
 tb/tb_dynamics_processor.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dynamics_processor.sv
`default_nettype none
// ===========================================================================
// dynamics_processor : noise gate, hard-knee compressor and makeup gain on a
// 16-bit signed sample stream. Gate logic is built only with DYN_GATE_EN.
// Rev 1.0
// ===========================================================================
module dynamics_processor #(
  parameter int ATTACK_SHIFT  = 2,
  parameter int RELEASE_SHIFT = 8,
  parameter int HOLD_SAMPLES  = 2400
) (
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [15:0] threshold_gate,
  input  logic [15:0] threshold_comp,
  input  logic [4:0]  ratio,
  input  logic [15:0] makeup,
  output logic        gate_open,
  output logic        comp_active
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ABS  = 3'd1,
    S_DIV  = 3'd2,
    S_MAK  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [15:0] smp, thr_comp_r, makeup_r, mag_r, env, quo;
  logic [4:0]  ratio_r, rem;
  logic [3:0]  cnt;
  logic        neg_r, comp_r;

  logic [15:0] mag_w, env_nxt, num_w, ymag_w, sat_w, res_w;
  logic [5:0]  trial_w;
  logic [4:0]  rem_nxt;
  logic        take_w;
  logic [31:0] prod_w;
  logic [19:0] scaled_w;
  logic        pass_w;

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_ABS;
      S_ABS:   state_nxt = S_DIV;
      S_DIV:   if (cnt == 4'd15) state_nxt = S_MAK;
      S_MAK:   state_nxt = S_OUT;
      S_OUT:   if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign in_ready  = (state == S_IDLE) && !avm_rst;
  assign out_valid = (state == S_OUT);

  always_comb begin
    // -32768 has no positive counterpart, so clamp it to full scale
    if (smp == 16'h8000)  mag_w = 16'h7fff;
    else if (smp[15])     mag_w = -smp;
    else                  mag_w = smp;

    if (mag_w > env) env_nxt = env + ((mag_w - env) >> ATTACK_SHIFT);
    else             env_nxt = env - ((env - mag_w) >> RELEASE_SHIFT);

    num_w = (mag_w > thr_comp_r) ? (mag_w - thr_comp_r) : 16'd0;

    // Remainder stays below the divisor (<= 31), so 5 bits suffice
    trial_w = {rem, quo[15]};
    take_w  = (trial_w >= {1'b0, ratio_r});
    rem_nxt = take_w ? 5'(trial_w - {1'b0, ratio_r}) : trial_w[4:0];

    ymag_w   = comp_r ? (thr_comp_r + quo) : mag_r;
    prod_w   = {16'd0, ymag_w} * {16'd0, makeup_r};
    scaled_w = prod_w[31:12];
    sat_w    = (scaled_w > 20'd32767) ? 16'h7fff : scaled_w[15:0];
    res_w    = pass_w ? (neg_r ? -sat_w : sat_w) : 16'd0;
  end

  logic unused_prod;
  assign unused_prod = ^prod_w[11:0];

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      smp         <= '0;
      thr_comp_r  <= '0;
      makeup_r    <= '0;
      ratio_r     <= 5'd1;
      mag_r       <= '0;
      env         <= '0;
      quo         <= '0;
      rem         <= '0;
      cnt         <= '0;
      neg_r       <= 1'b0;
      comp_r      <= 1'b0;
      out_data    <= '0;
      comp_active <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            smp        <= in_data;
            thr_comp_r <= threshold_comp;
            makeup_r   <= makeup;
            ratio_r    <= (ratio == 5'd0) ? 5'd1 : ratio;
          end
        end
        S_ABS: begin
          neg_r  <= smp[15];
          mag_r  <= mag_w;
          env    <= env_nxt;
          comp_r <= (mag_w > thr_comp_r);
          quo    <= num_w;
          rem    <= '0;
          cnt    <= '0;
        end
        S_DIV: begin
          // Dividend shifts out of quo's MSB while quotient bits shift in
          quo <= {quo[14:0], take_w};
          rem <= rem_nxt;
          cnt <= cnt + 4'd1;
        end
        S_MAK: begin
          out_data    <= res_w;
          comp_active <= comp_r;
        end
        default: ;
      endcase
    end
  end

`ifdef DYN_GATE_EN
  localparam int HOLD_W = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES + 1) : 1;

  logic [15:0]       thr_gate_r;
  logic [HOLD_W-1:0] hold_cnt;
  logic              gate_r;

  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      thr_gate_r <= '0;
      hold_cnt   <= '0;
      gate_r     <= 1'b0;
      gate_open  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) thr_gate_r <= threshold_gate;
        S_ABS: begin
          if (env_nxt >= thr_gate_r) begin
            gate_r   <= 1'b1;
            hold_cnt <= HOLD_W'(HOLD_SAMPLES);
          end else if (hold_cnt != '0) begin
            gate_r   <= 1'b1;
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end else begin
            gate_r   <= 1'b0;
          end
        end
        S_MAK:   gate_open <= gate_r;
        default: ;
      endcase
    end
  end

  assign pass_w = gate_r;
`else
  assign gate_open = 1'b1;
  assign pass_w    = 1'b1;

  logic unused_gate;
  assign unused_gate = ^{threshold_gate, env};
`endif

endmodule
`default_nettype wire

// File: tb/tb_dynamics_processor.sv
`default_nettype none
// Bench for dynamics_processor: directed cases plus randomized samples
// compared against an arithmetic reference model.
module tb_dynamics_processor;

  localparam int ATT  = 0;
  localparam int REL  = 0;
  localparam int HOLD = 4;
`ifdef DYN_GATE_EN
  localparam bit GATE_ON = 1'b1;
`else
  localparam bit GATE_ON = 1'b0;
`endif
  // Value of gate_open while reset is asserted
  localparam bit GATE_RST = !GATE_ON;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] threshold_gate = '0;
  logic [15:0] threshold_comp = '0;
  logic [4:0]  ratio = '0;
  logic [15:0] makeup = '0;
  logic        gate_open;
  logic        comp_active;

  int n_vec = 0;
  int n_err = 0;
  int env_m = 0;
  int hold_m = 0;
  logic [15:0] last_out;

  dynamics_processor #(
    .ATTACK_SHIFT (ATT),
    .RELEASE_SHIFT(REL),
    .HOLD_SAMPLES (HOLD)
  ) dut (
    .avm_clk       (clk),
    .avm_rst       (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .threshold_gate(threshold_gate),
    .threshold_comp(threshold_comp),
    .ratio         (ratio),
    .makeup        (makeup),
    .gate_open     (gate_open),
    .comp_active   (comp_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference: envelope, gate with hold, compressor, makeup, sign restore.
  task automatic model(input int s, input int tg, input int tc, input int r, input int mk,
                       output int y, output bit g, output bit c);
    int mag, rr;
    longint p;
    mag = (s < 0) ? -s : s;
    if (mag > 32767) mag = 32767;
    if (mag > env_m) env_m = env_m + (mag - env_m) / (1 << ATT);
    else             env_m = env_m - (env_m - mag) / (1 << REL);
    if (!GATE_ON) g = 1'b1;
    else if (env_m >= tg) begin g = 1'b1; hold_m = HOLD; end
    else if (hold_m > 0) begin g = 1'b1; hold_m = hold_m - 1; end
    else g = 1'b0;
    rr = (r == 0) ? 1 : r;
    c  = (mag > tc);
    p  = c ? longint'(tc + (mag - tc) / rr) : longint'(mag);
    p  = (p * mk) / 4096;
    if (p > 32767) p = 32767;
    if (!g) p = 0;
    y = (s < 0) ? -int'(p) : int'(p);
  endtask

  task automatic drive_accept(input logic [15:0] s, input logic [15:0] tg, input logic [15:0] tc,
                              input logic [4:0] r, input logic [15:0] mk);
    int t;
    t = 0;
    @(negedge clk);
    in_data = s; threshold_gate = tg; threshold_comp = tc; ratio = r; makeup = mk;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    // Scramble inputs after the accept edge; the sample in flight must not notice
    in_valid = 1'b0;
    in_data = 16'($urandom);
    threshold_gate = 16'($urandom);
    threshold_comp = 16'($urandom);
    ratio = 5'($urandom);
    makeup = 16'($urandom);
  endtask

  task automatic collect(output int l);
    l = 0;
    do begin @(negedge clk); l++; end while (!out_valid && l < 100);
  endtask

  task automatic run(input string tag, input logic [15:0] s, input logic [15:0] tg,
                     input logic [15:0] tc, input logic [4:0] r, input logic [15:0] mk,
                     input int stall);
    int y, l;
    bit g, c;
    logic [15:0] held;
    drive_accept(s, tg, tc, r, mk);
    collect(l);
    model($signed(s), tg, tc, r, mk, y, g, c);
    check({tag, "_lat"},  l, 32'd19);
    check({tag, "_data"}, out_data, y[15:0]);
    check({tag, "_gate"}, gate_open, g);
    check({tag, "_comp"}, comp_active, c);
    last_out = out_data;
    held = out_data;
    in_valid = 1'b1;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check({tag, "_hold"}, {out_valid, in_ready, out_data}, {1'b1, 1'b0, held});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_xfer"}, {out_valid, in_ready}, {1'b0, 1'b1});
  endtask

  initial begin
    int l;
    bit seen;
    logic [15:0] s, tg, tc, mk;
    logic [4:0] r;

    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", out_valid, 1'b0);
    check("rst_ready", in_ready, 1'b0);
    check("rst_data",  out_data, 16'd0);
    check("rst_gate",  gate_open, GATE_RST);
    check("rst_comp",  comp_active, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("rel_ready", in_ready, 1'b1);

    // Bypass
    run("byp_pos", 16'd1000, 16'd0, 16'd32767, 5'd1, 16'd4096, 0);
    check("byp_pos_k", last_out, 16'd1000);
    run("byp_neg", 16'hfc18, 16'd0, 16'd32767, 5'd1, 16'd4096, 1);
    check("byp_neg_k", last_out, 16'hfc18);

    // Compression
    run("cmp_pos", 16'd20000, 16'd0, 16'd8000, 5'd4, 16'd4096, 2);
    check("cmp_pos_k", {comp_active, last_out}, {1'b1, 16'd11000});
    run("cmp_neg", 16'hb1e0, 16'd0, 16'd8000, 5'd4, 16'd4096, 0);
    check("cmp_neg_k", last_out, 16'hd508);
    run("cmp_r0", 16'd20000, 16'd0, 16'd8000, 5'd0, 16'd4096, 0);
    check("cmp_r0_k", last_out, 16'd20000);
    run("cmp_low", 16'd5000, 16'd0, 16'd8000, 5'd4, 16'd4096, 0);
    check("cmp_low_k", {comp_active, last_out}, {1'b0, 16'd5000});
    run("cmp_t0", 16'd300, 16'd0, 16'd0, 5'd3, 16'd4096, 0);
    check("cmp_t0_k", {comp_active, last_out}, {1'b1, 16'd100});

    // Makeup saturation
    run("mk_sat", 16'd20000, 16'd0, 16'd32767, 5'd1, 16'd8192, 0);
    check("mk_sat_k", last_out, 16'd32767);
    run("mk_min", 16'h8000, 16'd0, 16'd32767, 5'd1, 16'd8192, 0);
    check("mk_min_k", last_out, 16'h8001);
    run("mk_x2", 16'd1000, 16'd0, 16'd32767, 5'd1, 16'd8192, 0);
    check("mk_x2_k", last_out, 16'd2000);

    // Gate with hold
    run("gt_open", 16'd6000, 16'd5000, 16'd32767, 5'd1, 16'd4096, 0);
    check("gt_open_k", {gate_open, last_out}, {1'b1, 16'd6000});
    for (int i = 0; i < 4; i++) begin
      run("gt_hold", 16'd100, 16'd5000, 16'd32767, 5'd1, 16'd4096, 0);
      check("gt_hold_k", {gate_open, last_out}, {1'b1, 16'd100});
    end
    run("gt_shut", 16'd100, 16'd5000, 16'd32767, 5'd1, 16'd4096, 0);
    check("gt_shut_k", {gate_open, last_out}, GATE_ON ? {1'b0, 16'd0} : {1'b1, 16'd100});
    run("gt_reopen", 16'd6000, 16'd5000, 16'd32767, 5'd1, 16'd4096, 0);
    check("gt_reopen_k", {gate_open, last_out}, {1'b1, 16'd6000});

    // Backpressure with a competing input offered
    run("bp", 16'd1234, 16'd0, 16'd32767, 5'd1, 16'd4096, 50);

    // Asynchronous reset while holding a result in OUT
    drive_accept(16'd3000, 16'd0, 16'd32767, 5'd1, 16'd4096);
    collect(l);
    check("out_reached", out_valid, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_data",  out_data, 16'd0);
    check("arst_gate",  gate_open, GATE_RST);
    check("arst_ready", in_ready, 1'b0);
    env_m = 0; hold_m = 0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("arst_rel_ready", in_ready, 1'b1);

    // Reset during DIV discards the sample and clears envelope/hold
    run("pre_div", 16'd6000, 16'd5000, 16'd32767, 5'd1, 16'd4096, 0);
    drive_accept(16'd100, 16'd5000, 16'd32767, 5'd1, 16'd4096);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    env_m = 0; hold_m = 0;
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("div_rst_noout", seen, 1'b0);
    run("post_rst", 16'd100, 16'd5000, 16'd32767, 5'd1, 16'd4096, 0);
    check("post_rst_k", last_out, GATE_ON ? 16'd0 : 16'd100);

    // Randomized
    for (int i = 0; i < 150; i++) begin
      s  = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
      tg = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 32767)) : 16'($urandom_range(0, 2000));
      tc = 16'($urandom_range(0, 32767));
      r  = 5'($urandom_range(0, 31));
      mk = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 8192));
      run("rnd", s, tg, tc, r, mk, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
